// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive capture block.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // True when the received parity bit agrees with the data's XOR for the mode.
  function automatic logic par_ok(input logic data_xor, input logic pbit, input int mode);
    return (mode == PAR_ODD) ? (data_xor ^ pbit) : ~(data_xor ^ pbit);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous word FIFO: registered read port (latency 1), count with an
// extra MSB so full and empty are distinct, and a same-cycle overflow strobe.
module uart_rx_fifo #(
  parameter int W  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_rd, do_wr;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_rd    = rd_en & ~empty;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_wr    = wr_en & (~full | do_rd);
  assign overflow = wr_en & full & ~do_rd;

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  // Pointers, count and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      if (do_wr) wptr <= wptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_capture.sv
// UART receiver: synchronizes the line, deserializes frames mid-bit, checks
// parity and stop bits, and buffers good words in a FIFO with sticky errors.
// CLKS_PER_BIT (G_CLOCK_FREQ / G_BAUDRATE) must be at least 4.
module uart_rx_capture
  import uart_rx_pkg::*;
#(
  parameter int G_CLOCK_FREQ        = 20000000,
  parameter int G_BAUDRATE          = 1000000,
  parameter int G_DATA_WIDTH        = 8,
  parameter int G_PARITY            = 0,
  parameter int G_STOP_BIT_NUMBER   = 1,
  parameter int G_FIRST_BIT         = 0,
  parameter int G_BUFFER_ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rx,
  input  logic                         i_rd_en,
  input  logic                         i_clr_err,
  output logic [G_DATA_WIDTH-1:0]      o_rd_data,
  output logic                         o_rd_valid,
  output logic [G_BUFFER_ADDR_WIDTH:0] o_count,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_overflow,
  output logic                         o_parity_err,
  output logic                         o_frame_err
);

  localparam int CLKS_PER_BIT = G_CLOCK_FREQ / G_BAUDRATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(G_DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(G_STOP_BIT_NUMBER - 1);

  logic rx_meta, rx_sync, rx_prev, fall;

  rx_state_t              state;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic                   stop_idx;
  logic [G_DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                   par_bad, frame_bad, stop_bad_now;
  logic                   wr_en, perr_set, ferr_set;
  logic                   fifo_ovf;

  // Two-stage synchronizer plus one history stage for edge detection; all
  // preset to idle-high so reset never fabricates a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall         = rx_prev & ~rx_sync;
  assign stop_bad_now = frame_bad | ~rx_sync;
  assign shreg_nxt    = (G_FIRST_BIT != 0) ? {shreg[G_DATA_WIDTH-2:0], rx_sync}
                                           : {rx_sync, shreg[G_DATA_WIDTH-1:1]};

  // Deserializer FSM: mid-bit sampling, registered write/error pulses issued
  // on the last stop sample so they act on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      frame_bad <= 1'b0;
      wr_en     <= 1'b0;
      perr_set  <= 1'b0;
      ferr_set  <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      perr_set <= 1'b0;
      ferr_set <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt       <= '0;
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          par_bad   <= 1'b0;
          frame_bad <= 1'b0;
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= shreg_nxt;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == DATA_LAST)
              state <= (G_PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= ~par_ok(^shreg, rx_sync, G_PARITY);
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              state    <= ST_IDLE;
              wr_en    <= ~(par_bad | stop_bad_now);
              perr_set <= par_bad;
              ferr_set <= stop_bad_now;
            end else begin
              frame_bad <= stop_bad_now;
              stop_idx  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overflow   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_overflow   <= fifo_ovf | (o_overflow   & ~i_clr_err);
      o_parity_err <= perr_set | (o_parity_err & ~i_clr_err);
      o_frame_err  <= ferr_set | (o_frame_err  & ~i_clr_err);
    end
  end

  uart_rx_fifo #(
    .W  (G_DATA_WIDTH),
    .AW (G_BUFFER_ADDR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (shreg),
    .rd_en    (i_rd_en),
    .rd_data  (o_rd_data),
    .rd_valid (o_rd_valid),
    .count    (o_count),
    .empty    (o_empty),
    .full     (o_full),
    .overflow (fifo_ovf)
  );

endmodule

// File: tb/tb_uart_rx_capture.sv
// Bench for uart_rx_capture: three differently configured receivers, a
// frame-level model (queue of expected words, flag bits) and a per-cycle
// read-port checker.
module tb_uart_rx_capture;

  localparam int N   = 3;
  localparam int CPB = 20;
  // inst0: 8N1 defaults; inst1: 7 bits even parity depth 4; inst2: 8 bits MSB first odd parity 2 stop depth 8
  localparam int DW  [N] = '{8, 7, 8};
  localparam int PAR [N] = '{0, 2, 1};
  localparam int STP [N] = '{1, 1, 2};
  localparam int FB  [N] = '{0, 0, 1};
  localparam int AW  [N] = '{8, 2, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx [N];
  logic rd_en [N];
  logic clr [N];
  logic [8:0] dout [N];
  logic [8:0] cnt  [N];
  logic vld [N], emp [N], ful [N], ovf [N], perr [N], ferr [N];

  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic [8:0] c0;
  logic [2:0] c1;
  logic [3:0] c2;
  assign dout[0] = {1'b0, d0};
  assign dout[1] = {2'b0, d1};
  assign dout[2] = {1'b0, d2};
  assign cnt[0]  = c0;
  assign cnt[1]  = {6'b0, c1};
  assign cnt[2]  = {5'b0, c2};

  uart_rx_capture #(.G_DATA_WIDTH(DW[0]), .G_PARITY(PAR[0]), .G_STOP_BIT_NUMBER(STP[0]),
                    .G_FIRST_BIT(FB[0]), .G_BUFFER_ADDR_WIDTH(AW[0])) u0 (
    .clk(clk), .rst(rst), .i_rx(rx[0]), .i_rd_en(rd_en[0]), .i_clr_err(clr[0]),
    .o_rd_data(d0), .o_rd_valid(vld[0]), .o_count(c0), .o_empty(emp[0]), .o_full(ful[0]),
    .o_overflow(ovf[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]));

  uart_rx_capture #(.G_DATA_WIDTH(DW[1]), .G_PARITY(PAR[1]), .G_STOP_BIT_NUMBER(STP[1]),
                    .G_FIRST_BIT(FB[1]), .G_BUFFER_ADDR_WIDTH(AW[1])) u1 (
    .clk(clk), .rst(rst), .i_rx(rx[1]), .i_rd_en(rd_en[1]), .i_clr_err(clr[1]),
    .o_rd_data(d1), .o_rd_valid(vld[1]), .o_count(c1), .o_empty(emp[1]), .o_full(ful[1]),
    .o_overflow(ovf[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]));

  uart_rx_capture #(.G_DATA_WIDTH(DW[2]), .G_PARITY(PAR[2]), .G_STOP_BIT_NUMBER(STP[2]),
                    .G_FIRST_BIT(FB[2]), .G_BUFFER_ADDR_WIDTH(AW[2])) u2 (
    .clk(clk), .rst(rst), .i_rx(rx[2]), .i_rd_en(rd_en[2]), .i_clr_err(clr[2]),
    .o_rd_data(d2), .o_rd_valid(vld[2]), .o_count(c2), .o_empty(emp[2]), .o_full(ful[2]),
    .o_overflow(ovf[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]));

  always #25 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Model state
  int   exp_q [N][$];
  bit   m_perr [N], m_ferr [N], m_ovf [N];
  bit   pend [N];
  int   frm_start [N];
  int   cnt_chg [N];
  logic [8:0] cnt_prev [N];
  bit   watch = 1'b0;
  bit   dipped = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  function automatic bit par_bit(input int i, input int data);
    int m = (1 << DW[i]) - 1;
    bit p = ^(data & m);
    return (PAR[i] == 1) ? ~p : p;
  endfunction

  // Per-cycle read port check: a pop request on a non-empty model FIFO must
  // yield exactly one valid word, the oldest one, on the next cycle.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        pend[i] = 1'b0;
      end else begin
        chk("rd_valid", i, vld[i], pend[i]);
        if (pend[i] && exp_q[i].size() > 0) begin
          chk("rd_data", i, dout[i], exp_q[i][0]);
          void'(exp_q[i].pop_front());
        end
        pend[i] = rd_en[i] && (exp_q[i].size() > 0);
        if (cnt[i] !== cnt_prev[i]) cnt_chg[i] = cyc;
        cnt_prev[i] = cnt[i];
        if (watch && i == 1 && cnt[1] !== 9'd4) dipped = 1'b1;
      end
    end
  end

  task automatic send(input int i, input int data, input bit bad_par, input int bad_stop);
    bit bits[$];
    int m = (1 << DW[i]) - 1;
    bits.push_back(1'b0);
    for (int k = 0; k < DW[i]; k++)
      bits.push_back((FB[i] != 0) ? data[DW[i]-1-k] : data[k]);
    if (PAR[i] != 0) bits.push_back(par_bit(i, data) ^ bad_par);
    for (int s = 0; s < STP[i]; s++) bits.push_back((bad_stop == s + 1) ? 1'b0 : 1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      @(posedge clk); #1 rx[i] = bits[b];
      if (b == 0) frm_start[i] = cyc;
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1 rx[i] = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    if (PAR[i] != 0 && bad_par) m_perr[i] = 1'b1;
    if (bad_stop != 0) m_ferr[i] = 1'b1;
    if (!(PAR[i] != 0 && bad_par) && bad_stop == 0) begin
      if (exp_q[i].size() == (1 << AW[i])) m_ovf[i] = 1'b1;
      else exp_q[i].push_back(data & m);
    end
  endtask

  task automatic rd(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1 rd_en[i] = 1'b1;
      @(posedge clk); #1 rd_en[i] = 1'b0;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic clear(input int i);
    @(posedge clk); #1 clr[i] = 1'b1;
    @(posedge clk); #1 clr[i] = 1'b0;
    m_perr[i] = 1'b0; m_ferr[i] = 1'b0; m_ovf[i] = 1'b0;
  endtask

  task automatic check_idle(input int i);
    int sz = exp_q[i].size();
    @(negedge clk);
    chk("count", i, cnt[i], sz);
    chk("empty", i, emp[i], sz == 0);
    chk("full", i, ful[i], sz == (1 << AW[i]));
    chk("overflow", i, ovf[i], m_ovf[i]);
    chk("parity_err", i, perr[i], m_perr[i]);
    chk("frame_err", i, ferr[i], m_ferr[i]);
  endtask

  task automatic check_reset(input int i);
    chk("rst_count", i, cnt[i], 0);
    chk("rst_empty", i, emp[i], 1);
    chk("rst_full", i, ful[i], 0);
    chk("rst_valid", i, vld[i], 0);
    chk("rst_data", i, dout[i], 0);
    chk("rst_flags", i, {ovf[i], perr[i], ferr[i]}, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      m_perr[i] = 1'b0; m_ferr[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1, i, data, bp, bs;
    for (int k = 0; k < N; k++) begin rx[k] = 1'b1; rd_en[k] = 1'b0; clr[k] = 1'b0; end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) check_reset(k);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // 0xA5 8N1
    send(0, 'hA5, 0, 0);
    lat0 = cnt_chg[0] - frm_start[0];
    @(negedge clk); chk("a5_count", 0, cnt[0], 1);
    check_idle(0);
    rd(0, 1);
    @(negedge clk); chk("a5_data", 0, dout[0], 'hA5);
    check_idle(0);

    // 0x3C with low stop bit, then clear
    send(0, 'h3C, 0, 1);
    @(negedge clk); chk("3c_ferr", 0, ferr[0], 1); chk("3c_count", 0, cnt[0], 0);
    check_idle(0);
    clear(0);
    check_idle(0);

    // clear held across the error-setting cycle: the set wins
    fork
      send(0, 'h3C, 0, 1);
      begin @(posedge clk); #1 clr[0] = 1'b1; repeat (lat0 - 1) @(posedge clk); #1 clr[0] = 1'b0; end
    join
    check_idle(0);
    clear(0);

    // 5-cycle glitch
    @(posedge clk); #1 rx[0] = 1'b0;
    repeat (5) @(posedge clk); #1 rx[0] = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check_idle(0);

    // even parity on 0x07
    tests++;
    if (par_bit(1, 7) != 1'b1) begin fails++; $display("FAIL par_pin[1]: got 0 expected 1"); end
    send(1, 'h07, 1, 0);
    @(negedge clk); chk("p07_perr", 1, perr[1], 1); chk("p07_count", 1, cnt[1], 0);
    check_idle(1);
    clear(1);
    send(1, 'h07, 0, 0);
    check_idle(1);
    rd(1, 1);
    @(negedge clk); chk("p07_data", 1, dout[1], 'h07);
    check_idle(1);

    // depth-4 fill and overflow
    for (int d = 1; d <= 5; d++) send(1, d, 0, 0);
    @(negedge clk);
    chk("fill_full", 1, ful[1], 1); chk("fill_count", 1, cnt[1], 4); chk("fill_ovf", 1, ovf[1], 1);
    check_idle(1);
    rd(1, 4);
    @(negedge clk); chk("drain_empty", 1, emp[1], 1);
    check_idle(1);
    clear(1);

    // read coincident with the write into a full FIFO
    send(1, 'h11, 0, 0);
    lat1 = cnt_chg[1] - frm_start[1];
    for (int d = 'h12; d <= 'h14; d++) send(1, d, 0, 0);
    check_idle(1);
    watch = 1'b1;
    fork
      send(1, 'h15, 0, 0);
      begin @(posedge clk); #1; repeat (lat1 - 1) @(posedge clk); #1 rd_en[1] = 1'b1; @(posedge clk); #1 rd_en[1] = 1'b0; end
    join
    watch = 1'b0;
    tests++;
    if (dipped) begin fails++; $display("FAIL full_rw_count[1]: got change expected 4 throughout"); end
    check_idle(1);
    rd(1, 4);
    check_idle(1);

    // MSB first
    send(2, 'h80, 0, 0);
    check_idle(2);
    rd(2, 1);
    @(negedge clk); chk("msb_data", 2, dout[2], 'h80);

    // reset mid-DATA
    @(posedge clk); #1 rx[0] = 1'b0;
    repeat (CPB) @(posedge clk); #1 rx[0] = 1'b1;
    repeat (CPB) @(posedge clk); #1 rx[0] = 1'b0;
    repeat (CPB / 2) @(posedge clk); #1 rst = 1'b1; rx[0] = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) check_reset(k);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk); check_reset(0);
    send(0, 'h55, 0, 0);
    check_idle(0);
    rd(0, 1);
    @(negedge clk); chk("post_rst_data", 0, dout[0], 'h55);

    // randomized traffic
    for (int n = 0; n < 45; n++) begin
      i    = $urandom_range(0, N - 1);
      data = int'($urandom);
      bp   = (PAR[i] != 0 && $urandom_range(0, 6) == 0) ? 1 : 0;
      bs   = ($urandom_range(0, 6) == 0) ? $urandom_range(1, STP[i]) : 0;
      send(i, data, bp[0], bs);
      if ($urandom_range(0, 2) == 0) rd(i, $urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) clear(i);
      check_idle(i);
    end
    for (int k = 0; k < N; k++) begin
      rd(k, exp_q[k].size() + 1);
      check_idle(k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_capture.md
UART_RX_CAPTURE -- requirements
Module: uart_rx_capture

Interface
REQ-001 Parameter G_CLOCK_FREQ, default 20000000, clk frequency in Hz.
REQ-002 Parameter G_BAUDRATE, default 1000000, line rate in bit/s; CLKS_PER_BIT = G_CLOCK_FREQ / G_BAUDRATE, which SHALL be at least 4.
REQ-003 Parameter G_DATA_WIDTH, default 8, data bits per frame (5..9).
REQ-004 Parameter G_PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter G_STOP_BIT_NUMBER, default 1, stop bits checked (1 or 2).
REQ-006 Parameter G_FIRST_BIT, default 0, bit order: 0 LSB first, 1 MSB first.
REQ-007 Parameter G_BUFFER_ADDR_WIDTH, default 8, FIFO depth is 2**G_BUFFER_ADDR_WIDTH.
REQ-008 Clock and reset: one clock, clk; reset rst is synchronous and active-high.
REQ-009 clk  in  1  system clock.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 i_rx  in  1  asynchronous serial line, idle high.
REQ-012 i_rd_en  in  1  pop request for one word.
REQ-013 i_clr_err  in  1  clears the sticky error flags.
REQ-014 o_rd_data  out  G_DATA_WIDTH  popped word.
REQ-015 o_rd_valid  out  1  one-cycle qualifier for o_rd_data.
REQ-016 o_count  out  G_BUFFER_ADDR_WIDTH+1  stored word count.
REQ-017 o_empty / o_full  out  1 each  FIFO status flags.
REQ-018 o_overflow, o_parity_err, o_frame_err  out  1 each  sticky error flags.

Function
REQ-019 i_rx SHALL pass through a 2-FF synchronizer; all decoding SHALL use the synchronized value.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE -> START on a synchronized falling edge.
REQ-022 START: at CLKS_PER_BIT/2 the line is sampled; low -> DATA, high -> IDLE (glitch rejected, nothing stored).
REQ-023 DATA: samples G_DATA_WIDTH bits, each at CLKS_PER_BIT after the previous sample, in the order set by G_FIRST_BIT.
REQ-024 After DATA, go to PARITY if G_PARITY != 0, otherwise to STOP.
REQ-025 PARITY: sample one bit and compare against odd/even parity of the data.
REQ-026 STOP: sample G_STOP_BIT_NUMBER bits; any low stop bit is a framing error.
REQ-027 After the last stop sample, return to IDLE; a falling edge on the following cycle SHALL be accepted.
REQ-028 A good frame SHALL be written to the FIFO on the cycle after the last stop sample.
REQ-029 Parity error: set o_parity_err and discard the frame.
REQ-030 Framing error: set o_frame_err and discard the frame.
REQ-031 Both errors in one frame: set both flags and discard the frame.
REQ-032 Write when full and no read in the same cycle: drop the word, set o_overflow, leave contents unchanged.
REQ-033 Write and read in the same cycle when full: accept both; o_count is unchanged.
REQ-034 i_rd_en while not empty: o_rd_data and o_rd_valid are presented on the next cycle (latency 1) and o_count decrements.
REQ-035 i_rd_en while empty: ignored, o_rd_valid stays 0.
REQ-036 Pointers wrap modulo depth; o_count SHALL use the extra MSB to tell full from empty.
REQ-037 Sticky flags hold until i_clr_err.
REQ-038 i_clr_err coincident with a new error: the set wins.

Reset
REQ-039 On rst: FSM returns to IDLE and pointers and o_count go to 0.
REQ-040 On rst: o_empty=1, o_full=0, o_rd_valid=0, o_rd_data=0, and all sticky flags are 0.
REQ-041 On rst: the synchronizer is preset to 1.
REQ-042 rst during a frame aborts the frame without storing it.
REQ-043 After rst, the first falling edge seen on or after the first post-reset cycle SHALL be decoded normally.

Structure
REQ-044 The shared package uart_rx_pkg SHALL hold the FSM state enum and the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
REQ-045 Storage SHALL be the sub-module uart_rx_fifo (synchronous FIFO: write/read ports, count, flags, overflow strobe).
REQ-046 The deserializer FSM SHALL live in uart_rx_capture.

Verification (defaults, 20 clk/bit)
REQ-047 Send 0xA5, 8N1 -> o_count=1 one cycle after the stop sample; i_rd_en gives o_rd_valid with 0xA5 next cycle; no flags set.
REQ-048 Send 0x3C with stop bit forced low -> o_frame_err=1, o_count=0; i_clr_err -> flag 0.
REQ-049 G_PARITY=2, send 0x07 with parity bit 0 -> o_parity_err=1, nothing stored.
REQ-050 G_PARITY=2, send 0x07 with parity bit 1 -> 0x07 stored, no flags.
REQ-051 5-clk low pulse on i_rx -> FSM back to IDLE, o_count=0, no flags.
REQ-052 G_BUFFER_ADDR_WIDTH=2: send 0x01..0x05 -> o_full=1, o_count=4, o_overflow=1; reads return 0x01..0x04, then o_empty=1.
REQ-053 G_BUFFER_ADDR_WIDTH=2: with o_full=1, pulse i_rd_en on the write cycle of a 5th frame -> o_count stays 4.
REQ-054 G_FIRST_BIT=1, send 0x80 -> 0x80 stored.
REQ-055 Assert rst mid-DATA -> all outputs take reset values; a following 0x55 frame is stored correctly.
